// File: rtl/alu_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_scheduler_pkg
// Shared types for the ALU issue path.
//   XLEN, ROB_TAG_LEN : datapath width and reorder-buffer tag width
//   INSN_FUNC         : ALU operation selector
//   INST_RS           : instruction as held in a reservation station
//   ALU_RESULT_ENTRY  : one buffered ALU result waiting for the CDB
//   ptr_width()       : pointer width helper that never returns 0
// ---------------------------------------------------------------------------
package alu_issue_scheduler_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 4;

  typedef enum logic [2:0] {
    FUNC_ADD = 3'd0,
    FUNC_SUB = 3'd1,
    FUNC_AND = 3'd2,
    FUNC_OR  = 3'd3,
    FUNC_XOR = 3'd4
  } INSN_FUNC;

  typedef struct packed {
    INSN_FUNC               func;
    logic [XLEN-1:0]        src1;
    logic [XLEN-1:0]        src2;
    logic [ROB_TAG_LEN-1:0] tag_dest;
    logic [ROB_TAG_LEN-1:0] insn_tag;
  } INST_RS;

  typedef struct packed {
    logic [XLEN-1:0]        value;
    logic [ROB_TAG_LEN-1:0] tag_dest;
    logic [ROB_TAG_LEN-1:0] insn_tag;
  } ALU_RESULT_ENTRY;

  // A one-entry structure still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_issue_scheduler_if
// Bundles the requester, ALU and CDB signals of the issue scheduler.
//   slave  : the scheduler side (takes requests / ALU results / cdb_ack,
//            drives grants, ALU instruction and the CDB offer)
//   master : the surrounding pipeline (reservation stations, ALU, CDB)
// ---------------------------------------------------------------------------
interface alu_issue_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import alu_issue_scheduler_pkg::*;

  // requesters
  logic [NUM_REQ-1:0]     req_valid;
  INST_RS                 req_insn [NUM_REQ];
  logic [NUM_REQ-1:0]     req_grant;
  logic                   squash;
  // ALU
  INST_RS                 alu_insn;
  logic                   alu_en;
  logic [XLEN-1:0]        alu_result;
  logic [ROB_TAG_LEN-1:0] alu_insn_tag;
  logic [ROB_TAG_LEN-1:0] alu_result_tag;
  logic                   alu_done;
  // CDB
  logic                   cdb_valid;
  logic [XLEN-1:0]        cdb_value;
  logic [ROB_TAG_LEN-1:0] cdb_tag;
  logic [ROB_TAG_LEN-1:0] cdb_insn_tag;
  logic                   cdb_ack;

  modport slave (
    input  req_valid, req_insn, squash,
    input  alu_result, alu_insn_tag, alu_result_tag, alu_done,
    input  cdb_ack,
    output req_grant, alu_insn, alu_en,
    output cdb_valid, cdb_value, cdb_tag, cdb_insn_tag
  );

  modport master (
    output req_valid, req_insn, squash,
    output alu_result, alu_insn_tag, alu_result_tag, alu_done,
    output cdb_ack,
    input  req_grant, alu_insn, alu_en,
    input  cdb_valid, cdb_value, cdb_tag, cdb_insn_tag
  );

endinterface

// File: rtl/alu_issue_scheduler_result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Small circular buffer of ALU results waiting for the CDB.
//   clock, reset_n : clock (rising edge) and async active-low reset
//   i_push, i_data : write one entry at the tail
//   i_pop          : retire the head entry (ignored when empty)
//   i_flush        : drop every entry and rewind both pointers
//   o_head         : head entry, all-zero while empty
//   o_full/o_empty : occupancy flags
// A push while full is accepted only if the head retires in the same cycle;
// otherwise the data is dropped and the assertion below reports it.
// ---------------------------------------------------------------------------
module result_fifo
  import alu_issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_push,
  input  ALU_RESULT_ENTRY i_data,
  input  logic            i_pop,
  input  logic            i_flush,
  output ALU_RESULT_ENTRY o_head,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ALU_RESULT_ENTRY  r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  // When full, the slot being written is the one the head vacates this edge.
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= w_count_next;
    end
  end

  // Storage carries no reset: the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  a_no_overflow : assert property (
    @(posedge clock) disable iff (!reset_n)
      !(i_push && !i_flush && o_full && !i_pop)
  ) else $error("result_fifo: push while full without pop, data dropped");

endmodule

// File: rtl/alu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// alu_issue_scheduler
// Picks one ready reservation-station entry per cycle (round-robin), sends it
// to a single ALU, and buffers ALU results until the CDB accepts them.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_issue_scheduler_if.slave (requests, grants, ALU, CDB)
// Issue is allowed only when the result buffer has room for the result the
// ALU returns, counting the slot freed by a same-cycle CDB accept.
// ---------------------------------------------------------------------------
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic                  clock,
  input logic                  reset_n,
  alu_issue_scheduler_if.slave bus
);

  localparam int RR_W   = ptr_width(NUM_REQ);
  localparam int INSN_W = $bits(INST_RS);

  logic [RR_W-1:0]    r_rr_ptr;
  logic [RR_W-1:0]    w_grant_idx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_issue;
  logic               w_issue_ok;
  logic               w_can_issue;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  ALU_RESULT_ENTRY    w_head;
  ALU_RESULT_ENTRY    w_push_data;
  logic [INSN_W-1:0]  w_insn_masked [NUM_REQ];
  logic [INSN_W-1:0]  w_alu_insn_vec;

  // (base + off) mod NUM_REQ, off < NUM_REQ
  function automatic logic [RR_W-1:0] wrap_add(input logic [RR_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[RR_W-1:0];
  endfunction

  // ---------------- arbitration ----------------
  assign w_pop       = !w_empty && bus.cdb_ack;
  assign w_can_issue = !w_full || w_pop;
  // Nothing is issued while reset is held, so every output reads zero.
  assign w_issue_ok  = reset_n && w_can_issue && !bus.squash;

  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found     = 1'b1;
        w_grant_idx = wrap_add(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found && w_issue_ok) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_issue = |w_grant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= wrap_add(w_grant_idx, 1);
    end
  end

  // ---------------- ALU instruction select ----------------
  // Grant is one-hot, so OR-ing the masked instructions acts as the mux and
  // yields all-zero when nothing is granted.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_insn_mask
      assign w_insn_masked[gi] = w_grant[gi] ? bus.req_insn[gi] : '0;
    end
  endgenerate

  always_comb begin
    w_alu_insn_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_alu_insn_vec = w_alu_insn_vec | w_insn_masked[k];
    end
  end

  assign bus.req_grant = w_grant;
  assign bus.alu_insn  = INST_RS'(w_alu_insn_vec);
  assign bus.alu_en    = w_issue;

  // ---------------- result buffer ----------------
  assign w_push      = bus.alu_done && !bus.squash;
  assign w_push_data = '{value:    bus.alu_result,
                         tag_dest: bus.alu_result_tag,
                         insn_tag: bus.alu_insn_tag};

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (bus.squash),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.cdb_valid    = !w_empty;
  assign bus.cdb_value    = w_head.value;
  assign bus.cdb_tag      = w_head.tag_dest;
  assign bus.cdb_insn_tag = w_head.insn_tag;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_scheduler
// Directed bench for alu_issue_scheduler with a single-cycle ALU model.
// ---------------------------------------------------------------------------
module tb_alu_issue_scheduler;
  import alu_issue_scheduler_pkg::*;

  logic clock;
  logic reset_n;
  logic force_done;
  int   n_checks;
  int   n_fail;
  int   ngrants;

  alu_issue_scheduler_if #(.NUM_REQ(4)) bus ();

  alu_issue_scheduler #(
    .NUM_REQ    (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [XLEN-1:0] alu_model(input INST_RS i);
    case (i.func)
      FUNC_ADD: return i.src1 + i.src2;
      FUNC_SUB: return i.src1 - i.src2;
      FUNC_AND: return i.src1 & i.src2;
      FUNC_OR:  return i.src1 | i.src2;
      FUNC_XOR: return i.src1 ^ i.src2;
      default:  return '0;
    endcase
  endfunction

  // Combinational ALU: result appears in the issue cycle.
  assign bus.alu_result     = alu_model(bus.alu_insn);
  assign bus.alu_result_tag = bus.alu_insn.tag_dest;
  assign bus.alu_insn_tag   = bus.alu_insn.insn_tag;
  assign bus.alu_done       = bus.alu_en | force_done;

  function automatic INST_RS make_insn(input INSN_FUNC f, input int a, input int b,
                                       input int td, input int it);
    INST_RS r;
    r.func     = f;
    r.src1     = XLEN'(a);
    r.src2     = XLEN'(b);
    r.tag_dest = ROB_TAG_LEN'(td);
    r.insn_tag = ROB_TAG_LEN'(it);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g [5];
    logic [3:0] exp_g3 [4];
    int         exp_v3 [4];
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    force_done = 1'b0;
    bus.req_valid = '0;
    bus.squash    = 1'b0;
    bus.cdb_ack   = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_insn[i] = make_insn(FUNC_ADD, 100 + i, i, i + 1, i + 8);

    // ---- reset state ----
    #2;
    chk("rst_cdb_valid", 128'(bus.cdb_valid), 128'(0));
    chk("rst_cdb_value", 128'(bus.cdb_value), 128'(0));
    chk("rst_count", 128'(dut.u_fifo.r_count), 128'(0));
    chk("rst_alu_en", 128'(bus.alu_en), 128'(0));
    #10;
    reset_n = 1'b1;

    // ---- round-robin over all four with cdb_ack held ----
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step();
    bus.req_valid = 4'hF;
    bus.cdb_ack   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rr_grant%0d", c), 128'(bus.req_grant), 128'(exp_g[c]));
      if (c == 1) begin
        chk("rr_cdb_value", 128'(bus.cdb_value), 128'(100));
        chk("rr_cdb_tag", 128'(bus.cdb_tag), 128'(1));
      end
      step();
    end
    bus.req_valid = '0;
    #1;
    chk("idle_grant", 128'(bus.req_grant), 128'(0));
    chk("idle_alu_en", 128'(bus.alu_en), 128'(0));
    chk("idle_alu_insn", 128'(bus.alu_insn), 128'(0));
    step();
    chk("drain_count", 128'(dut.u_fifo.r_count), 128'(0));

    // ---- ADD 5+7 tag 3 (rr_ptr=1, only requester 0 ready) ----
    bus.req_insn[0] = make_insn(FUNC_ADD, 5, 7, 3, 6);
    bus.req_valid   = 4'b0001;
    bus.cdb_ack     = 1'b0;
    #1;
    chk("add_grant", 128'(bus.req_grant), 128'(4'b0001));
    chk("add_alu_en", 128'(bus.alu_en), 128'(1));
    chk("add_alu_insn", 128'(bus.alu_insn), 128'(make_insn(FUNC_ADD, 5, 7, 3, 6)));
    step();
    bus.req_valid = '0;
    #1;
    chk("add_cdb_valid", 128'(bus.cdb_valid), 128'(1));
    chk("add_cdb_value", 128'(bus.cdb_value), 128'(12));
    chk("add_cdb_tag", 128'(bus.cdb_tag), 128'(3));
    chk("add_cdb_insn_tag", 128'(bus.cdb_insn_tag), 128'(6));
    bus.cdb_ack = 1'b1;
    step();
    bus.cdb_ack = 1'b0;
    #1;
    chk("add_empty_valid", 128'(bus.cdb_valid), 128'(0));
    chk("add_empty_value", 128'(bus.cdb_value), 128'(0));

    // ---- back-pressure: cdb_ack low, continuous requests (rr_ptr=1) ----
    for (int i = 0; i < 4; i++) bus.req_insn[i] = make_insn(FUNC_ADD, 200 + i, 10 * i, i + 1, i + 8);
    exp_g3 = '{4'b0010, 4'b0100, 4'b0000, 4'b0000};
    exp_v3 = '{0, 211, 211, 211};
    ngrants = 0;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_grant%0d", c), 128'(bus.req_grant), 128'(exp_g3[c]));
      chk($sformatf("bp_value%0d", c), 128'(bus.cdb_value), 128'(exp_v3[c]));
      if (bus.req_grant != '0) ngrants++;
      step();
    end
    chk("bp_num_grants", 128'(ngrants), 128'(2));
    chk("bp_count", 128'(dut.u_fifo.r_count), 128'(2));
    chk("bp_cdb_valid", 128'(bus.cdb_valid), 128'(1));
    chk("bp_cdb_tag", 128'(bus.cdb_tag), 128'(2));

    // ---- full: pulse cdb_ack with pending requests (rr_ptr=3) ----
    bus.cdb_ack = 1'b1;
    #1;
    chk("full_pop_grant", 128'(bus.req_grant), 128'(4'b1000));
    step();
    bus.cdb_ack = 1'b0;
    #1;
    chk("full_count", 128'(dut.u_fifo.r_count), 128'(2));
    chk("full_head1", 128'(bus.cdb_value), 128'(222));
    chk("full_head1_tag", 128'(bus.cdb_tag), 128'(3));
    chk("full_no_grant", 128'(bus.req_grant), 128'(0));
    bus.req_valid = '0;
    bus.cdb_ack   = 1'b1;
    step();
    chk("full_head2", 128'(bus.cdb_value), 128'(233));
    chk("full_head2_tag", 128'(bus.cdb_tag), 128'(4));
    step();
    bus.cdb_ack = 1'b0;
    #1;
    chk("full_drained", 128'(dut.u_fifo.r_count), 128'(0));

    // ---- squash with two buffered results and a possible issue (rr_ptr=0) ----
    bus.req_valid = 4'hF;
    #1;
    chk("sq_fill_grant0", 128'(bus.req_grant), 128'(4'b0001));
    step();
    chk("sq_fill_grant1", 128'(bus.req_grant), 128'(4'b0010));
    step();
    bus.squash  = 1'b1;
    bus.cdb_ack = 1'b1;
    force_done  = 1'b1;
    #1;
    chk("sq_grant", 128'(bus.req_grant), 128'(0));
    chk("sq_alu_en", 128'(bus.alu_en), 128'(0));
    chk("sq_count_before", 128'(dut.u_fifo.r_count), 128'(2));
    step();
    bus.squash  = 1'b0;
    bus.cdb_ack = 1'b0;
    force_done  = 1'b0;
    #1;
    chk("sq_cdb_valid", 128'(bus.cdb_valid), 128'(0));
    chk("sq_count", 128'(dut.u_fifo.r_count), 128'(0));
    chk("sq_rr_kept", 128'(bus.req_grant), 128'(4'b0100));
    step();
    bus.req_valid = '0;
    #1;
    chk("pre_rst_valid", 128'(bus.cdb_valid), 128'(1));
    chk("pre_rst_value", 128'(bus.cdb_value), 128'(222));

    // ---- asynchronous reset mid-stream (rr_ptr=3, one entry buffered) ----
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_cdb_valid", 128'(bus.cdb_valid), 128'(0));
    chk("arst_cdb_value", 128'(bus.cdb_value), 128'(0));
    chk("arst_cdb_tag", 128'(bus.cdb_tag), 128'(0));
    chk("arst_cdb_insn_tag", 128'(bus.cdb_insn_tag), 128'(0));
    chk("arst_count", 128'(dut.u_fifo.r_count), 128'(0));
    bus.req_valid = 4'hF;
    #1;
    chk("arst_grant", 128'(bus.req_grant), 128'(0));
    chk("arst_alu_insn", 128'(bus.alu_insn), 128'(0));
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_grant", 128'(bus.req_grant), 128'(4'b0001));
    step();
    chk("post_rst_grant2", 128'(bus.req_grant), 128'(4'b0010));
    chk("post_rst_value", 128'(bus.cdb_value), 128'(200));
    bus.req_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of reservation-station requesters.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: result-buffer entries between ALU and CDB.
REQ-003 SHALL have port clock  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  requester i holds a ready ALU instruction.
REQ-006 SHALL have port req_insn  input  NUM_REQ x INST_RS  instruction per requester.
REQ-007 SHALL have port req_grant  output  NUM_REQ  one-hot or zero; requester i issued this cycle.
REQ-008 SHALL have port squash  input  1  flush all buffered and in-flight results.
REQ-009 SHALL have port alu_insn  output  INST_RS  instruction driven to the ALU.
REQ-010 SHALL have port alu_en  output  1  ALU enable.
REQ-011 SHALL have port alu_result  input  XLEN  ALU result.
REQ-012 SHALL have port alu_insn_tag  input  ROB_TAG_LEN  ALU instruction tag.
REQ-013 SHALL have port alu_result_tag  input  ROB_TAG_LEN  ALU destination tag.
REQ-014 SHALL have port alu_done  input  1  ALU result valid.
REQ-015 SHALL have port cdb_valid  output  1  buffered result offered to the CDB.
REQ-016 SHALL have port cdb_value  output  XLEN  head-entry result.
REQ-017 SHALL have port cdb_tag  output  ROB_TAG_LEN  head-entry destination tag.
REQ-018 SHALL have port cdb_insn_tag  output  ROB_TAG_LEN  head-entry instruction tag.
REQ-019 SHALL have port cdb_ack  input  1  CDB accepted the head entry this cycle.

Function
REQ-020 SHALL compute pop = cdb_valid && cdb_ack, and can_issue = (count < FIFO_DEPTH) || pop.
REQ-021 SHALL grant, combinationally, at most one requester per cycle, and only when can_issue && !squash.
REQ-022 SHALL arbitrate round-robin: search starts at rr_ptr, upward with wrap; first req_valid wins.
REQ-023 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ at the edge after a grant; rr_ptr SHALL be unchanged when there is no grant.
REQ-024 SHALL drive alu_insn = req_insn[granted] and alu_en = 1 on a grant; otherwise alu_insn SHALL be all-zero and alu_en = 0.
REQ-025 SHALL push {alu_result, alu_result_tag, alu_insn_tag} into the FIFO at the edge when alu_done && !squash; issue-to-buffer latency is 1 cycle and issue-to-cdb_valid is at most 1 cycle when empty.
REQ-026 SHALL drive cdb_valid = (count != 0) and cdb_value/cdb_tag/cdb_insn_tag from the head entry, registered, zero when empty.
REQ-027 SHALL leave count unchanged on simultaneous push and pop when full, and SHALL accept the push.
REQ-028 SHALL present entries in strict FIFO order; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 SHALL treat a push when count == FIFO_DEPTH with no pop as a protocol error, flagged by a simulation assertion, with the data dropped.
REQ-030 SHALL, while squash is high: issue no grant, ignore alu_done, and reset count and pointers to 0 at the next edge; rr_ptr SHALL be kept; cdb_valid SHALL be 0 the following cycle.
REQ-031 SHALL hold cdb outputs stable while cdb_valid && !cdb_ack.

Reset
REQ-032 SHALL, on reset_n low, immediately and asynchronously clear count, read/write pointers, rr_ptr, cdb_valid and cdb data to 0.
REQ-033 SHALL discard buffered results when reset is asserted mid-operation; the first grant after release SHALL go to the lowest valid index.

Structure
REQ-034 SHALL take INST_RS, INSN_FUNC, XLEN and ROB_TAG_LEN from the existing shared headers.
REQ-035 SHALL add a shared-package struct ALU_RESULT_ENTRY {value, tag_dest, insn_tag}.
REQ-036 SHALL implement the buffer as one sub-module, result_fifo, with push/pop/flush/full/empty; the arbiter SHALL stay inline.

Verification
REQ-037 The bench SHALL drive req_valid=4'b1111 with cdb_ack=1 held and check grants 0,1,2,3,0 on consecutive cycles.
REQ-038 The bench SHALL hold cdb_ack=0 with continuous requests and check that exactly 2 grants occur, then req_grant=0, count=2, and cdb_value holds the first result.
REQ-039 The bench SHALL, with the FIFO full, pulse cdb_ack with a pending request and check a same-cycle grant, count staying 2, and in-order output.
REQ-040 The bench SHALL issue ADD 5+7 tag 3 and check cdb_valid=1, cdb_value=12, cdb_tag=3 one cycle later.
REQ-041 The bench SHALL raise squash with 2 entries buffered plus an issue and check no grant, then cdb_valid=0 and count=0 next cycle.
REQ-042 The bench SHALL assert reset_n=0 mid-stream, away from any clock edge, and check all outputs zero immediately and the first post-reset grant to index 0.
